sriz_fetch_unit: RTL and testbench

//  Multi-cycle instruction fetch front end for the sriz core, replacing the fixed-PC, single-cycle fetch path.

---
 rtl/sriz_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_sriz_fetch_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sriz_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, keeps at most one word request in flight,
// and buffers PC-tagged responses in a prefetch FIFO that feeds the decode stage.
module sriz_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h8000_0000),
  parameter int              FIFO_DEPTH = 4,
  localparam int             AW         = $clog2(FIFO_DEPTH),
  localparam int             CW         = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [31:0]     rsp_data,
  input  logic            rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic [CW-1:0]   fifo_count,
  output logic [1:0]      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready. Once req_valid is
  // raised it stays high with a stable req_addr until req_ready. rsp_valid is never back-pressured.
  typedef enum logic [1:0] {ISSUE = 2'd0, WAIT_GNT = 2'd1, WAIT_RSP = 2'd2, DRAIN = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            stopped_q, stopped_d;
  logic            flushed_q, flushed_d;
  logic            run_q;
  logic            push, pop;
  logic [XLEN-1:0] redir_pc;

  logic [31:0]     data_q [FIFO_DEPTH];
  logic [XLEN-1:0] pc_q   [FIFO_DEPTH];
  logic            err_q  [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;

  assign redir_pc = redirect_pc & ~XLEN'(3);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    stopped_d  = stopped_q;
    flushed_d  = flushed_q;
    req_valid  = 1'b0;
    req_addr   = addr_q;
    push       = 1'b0;
    case (state_q)
      ISSUE: begin
        req_addr  = fetch_pc_q;
        req_valid = run_q && !halt && !stopped_q && (count_q < CW'(FIFO_DEPTH));
        if (req_valid) begin
          addr_d = fetch_pc_q;
          if (req_ready) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            state_d    = redirect_valid ? DRAIN : WAIT_RSP;
          end else begin
            state_d   = WAIT_GNT;
            flushed_d = redirect_valid;
          end
        end
      end
      WAIT_GNT: begin
        // flushed_q marks a pending request whose response must be thrown away
        req_valid = 1'b1;
        if (req_ready) begin
          state_d   = (flushed_q || redirect_valid) ? DRAIN : WAIT_RSP;
          flushed_d = 1'b0;
          if (!flushed_q) fetch_pc_d = addr_q + XLEN'(4);
        end else if (redirect_valid) begin
          flushed_d = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid) begin
          state_d = ISSUE;
          if (!redirect_valid) begin
            push = 1'b1;
            if (rsp_err) stopped_d = 1'b1;
          end
        end else if (redirect_valid) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rsp_valid) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redir_pc;
      stopped_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ISSUE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      stopped_q  <= 1'b0;
      flushed_q  <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      stopped_q  <= stopped_d;
      flushed_q  <= flushed_d;
      run_q      <= 1'b1;
    end
  end

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= rsp_data;
      pc_q[wr_ptr_q]   <= addr_q;
      err_q[wr_ptr_q]  <= rsp_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign inst       = inst_valid ? data_q[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? pc_q[rd_ptr_q]   : '0;
  assign inst_err   = inst_valid ? err_q[rd_ptr_q]  : 1'b0;
  assign fifo_count = count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sriz_fetch_unit.sv
// Bench for sriz_fetch_unit: directed corner sequences, a redirect-address table, and a random
// run where the bench plays the memory and checks the instruction stream against a PC model.
module tb_sriz_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        inst_valid, inst_ready, inst_err;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid, halt;
  logic [31:0] redirect_pc;
  logic [2:0]  fifo_count;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  sriz_fetch_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_err(inst_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .fifo_count(fifo_count), .dbg_state(dbg_state)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h13a5_0f03;
  endfunction

  function automatic logic err_f(input logic [31:0] a);
    return (a[6:2] == 5'h13);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req_ready = 0; rsp_valid = 0; rsp_data = 0; rsp_err = 0;
    inst_ready = 0; redirect_valid = 0; redirect_pc = 0; halt = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, RST_PC);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_err", inst_err, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("release_no_req_yet", req_valid, 0);
  endtask

  // Grants the next request and answers it in the following cycle; returns the granted address.
  task automatic fetch_one(input logic [31:0] data, input logic err, output logic [31:0] addr);
    int n;
    n = 0;
    req_ready = 1;
    #1;
    while (!req_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_valid) begin
      chk("fetch_timeout", 0, 1);
      addr = '0;
      req_ready = 0;
      return;
    end
    addr = req_addr;
    @(negedge clk);
    req_ready = 0;
    rsp_valid = 1; rsp_data = data; rsp_err = err;
    @(negedge clk);
    rsp_valid = 0; rsp_err = 0;
  endtask

  initial begin
    logic [31:0] a, p, exp_pc, pend_addr, prev_addr;
    bit pend, stop_m, prev_wait;
    int dly, pops;

    vecs[0] = '{32'h8000_0100, 32'h8000_0100};
    vecs[1] = '{32'h0000_0003, 32'h0000_0000};
    vecs[2] = '{32'h1234_5677, 32'h1234_5674};
    vecs[3] = '{32'hffff_fffe, 32'hffff_fffc};
    vecs[4] = '{32'h8000_0201, 32'h8000_0200};

    // Reset release and first fetch
    do_reset();
    req_ready = 1;
    @(negedge clk); #1;
    chk("t1_first_req_valid", req_valid, 1);
    chk("t1_first_req_addr", req_addr, RST_PC);
    @(negedge clk); #1;
    chk("t1_wait_rsp_no_req", req_valid, 0);
    rsp_valid = 1; rsp_data = 32'h0000_0413;
    @(negedge clk);
    rsp_valid = 0;
    #1;
    chk("t1_inst_valid", inst_valid, 1);
    chk("t1_inst", inst, 32'h0000_0413);
    chk("t1_inst_pc", inst_pc, RST_PC);
    chk("t1_inst_err", inst_err, 0);
    chk("t1_second_req_addr", req_addr, 32'h8000_0004);

    // FIFO fills to depth with no consumer
    fetch_one(mem_f(32'h8000_0004), 0, a); chk("t2_addr4", a, 32'h8000_0004);
    fetch_one(mem_f(32'h8000_0008), 0, a); chk("t2_addr8", a, 32'h8000_0008);
    fetch_one(mem_f(32'h8000_000c), 0, a); chk("t2_addrc", a, 32'h8000_000c);
    #1;
    chk("t2_full_count", fifo_count, 4);
    req_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t2_full_no_req", req_valid, 0);
      @(negedge clk);
    end
    req_ready = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(RST_PC + 32'(4 * i));
    inst_ready = 1;
    #1 chk("t2_head_pc", inst_pc, exp_q.pop_front());
    @(negedge clk);
    inst_ready = 0;
    #1;
    chk("t2_after_pop_count", fifo_count, 3);
    chk("t2_after_pop_req", req_valid, 1);
    chk("t2_after_pop_addr", req_addr, 32'h8000_0010);
    fetch_one(mem_f(32'h8000_0010), 0, a); chk("t2_addr10", a, 32'h8000_0010);
    exp_q.push_back(32'h8000_0010);
    #1;
    chk("t2_refull_count", fifo_count, 4);
    chk("t2_single_req", req_valid, 0);
    for (int i = 0; i < 2; i++) begin
      inst_ready = 1;
      #1;
      p = exp_q.pop_front();
      chk("t2_drain_pc", inst_pc, p);
      chk("t2_drain_inst", inst, mem_f(p));
      @(negedge clk);
    end
    inst_ready = 0;
    req_ready = 1;
    @(negedge clk);
    req_ready = 0;
    #1 chk("t3_pre_count", fifo_count, 2);

    // Redirect while a response is outstanding
    redirect_valid = 1; redirect_pc = 32'h8000_0100;
    @(negedge clk);
    redirect_valid = 0;
    #1;
    chk("t3_flushed_valid", inst_valid, 0);
    chk("t3_flushed_count", fifo_count, 0);
    chk("t3_drain_no_req", req_valid, 0);
    rsp_valid = 1; rsp_data = mem_f(32'h8000_0014);
    @(negedge clk);
    rsp_valid = 0;
    #1;
    chk("t3_stale_dropped", fifo_count, 0);
    chk("t3_req_valid", req_valid, 1);
    chk("t3_req_addr", req_addr, 32'h8000_0100);
    fetch_one(mem_f(32'h8000_0100), 0, a); chk("t3_addr", a, 32'h8000_0100);
    #1;
    chk("t3_inst_pc", inst_pc, 32'h8000_0100);
    chk("t3_inst", inst, mem_f(32'h8000_0100));

    // Grant stalled three cycles with a redirect in the second
    inst_ready = 1;
    #1 chk("t4_c1_addr", req_addr, 32'h8000_0104);
    @(negedge clk);
    inst_ready = 0;
    #1;
    chk("t4_c2_valid", req_valid, 1);
    chk("t4_c2_addr", req_addr, 32'h8000_0104);
    redirect_valid = 1; redirect_pc = 32'h8000_0300;
    @(negedge clk);
    redirect_valid = 0;
    #1;
    chk("t4_c3_valid", req_valid, 1);
    chk("t4_c3_addr", req_addr, 32'h8000_0104);
    @(negedge clk);
    req_ready = 1;
    #1 chk("t4_grant_addr", req_addr, 32'h8000_0104);
    @(negedge clk);
    req_ready = 0;
    #1 chk("t4_drain_no_req", req_valid, 0);
    rsp_valid = 1; rsp_data = mem_f(32'h8000_0104);
    @(negedge clk);
    rsp_valid = 0;
    #1;
    chk("t4_dropped", fifo_count, 0);
    chk("t4_req_valid", req_valid, 1);
    chk("t4_req_addr", req_addr, 32'h8000_0300);
    fetch_one(mem_f(32'h8000_0300), 0, a); chk("t4_addr", a, 32'h8000_0300);
    #1 chk("t4_inst_pc", inst_pc, 32'h8000_0300);

    // Access fault stops fetch until a redirect
    do_reset();
    fetch_one(mem_f(32'h8000_0000), 0, a); chk("t5_addr0", a, 32'h8000_0000);
    fetch_one(mem_f(32'h8000_0004), 0, a); chk("t5_addr4", a, 32'h8000_0004);
    fetch_one(mem_f(32'h8000_0008), 1, a); chk("t5_addr8", a, 32'h8000_0008);
    req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t5_stopped_no_req", req_valid, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      inst_ready = 1;
      #1;
      chk("t5_pc", inst_pc, RST_PC + 32'(4 * i));
      chk("t5_err", inst_err, (i == 2) ? 1 : 0);
      @(negedge clk);
    end
    inst_ready = 0;
    #1;
    chk("t5_empty", inst_valid, 0);
    chk("t5_still_stopped", req_valid, 0);
    redirect_valid = 1; redirect_pc = 32'h8000_0200;
    @(negedge clk);
    redirect_valid = 0;
    #1;
    chk("t5_resume_valid", req_valid, 1);
    chk("t5_resume_addr", req_addr, 32'h8000_0200);
    fetch_one(mem_f(32'h8000_0200), 0, a); chk("t5_addr200", a, 32'h8000_0200);
    #1;
    chk("t5_inst_pc", inst_pc, 32'h8000_0200);
    chk("t5_inst_err", inst_err, 0);

    // halt during an outstanding response
    req_ready = 1; inst_ready = 1;
    @(negedge clk);
    req_ready = 0; inst_ready = 0; halt = 1;
    #1 chk("t6_wait_no_req", req_valid, 0);
    @(negedge clk);
    rsp_valid = 1; rsp_data = mem_f(32'h8000_0204);
    @(negedge clk);
    rsp_valid = 0;
    #1;
    chk("t6_pushed_valid", inst_valid, 1);
    chk("t6_pushed_pc", inst_pc, 32'h8000_0204);
    chk("t6_halt_no_req", req_valid, 0);
    req_ready = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 chk("t6_halt_hold", req_valid, 0);
    end
    halt = 0;
    #1;
    chk("t6_resume_valid", req_valid, 1);
    chk("t6_resume_addr", req_addr, 32'h8000_0208);
    halt = 1; req_ready = 0;

    // PC wraps past the top of the address space
    redirect_valid = 1; redirect_pc = 32'hffff_fffc;
    @(negedge clk);
    redirect_valid = 0; halt = 0;
    fetch_one(mem_f(32'hffff_fffc), 0, a); chk("wrap_addr", a, 32'hffff_fffc);
    #1;
    chk("wrap_next_addr", req_addr, 32'h0000_0000);
    chk("wrap_inst_pc", inst_pc, 32'hffff_fffc);

    // Redirect address table
    for (int i = 0; i < 5; i++) begin
      do_reset();
      halt = 1;
      @(negedge clk);
      redirect_valid = 1; redirect_pc = vecs[i].rpc;
      #1 chk("tbl_halt_no_req", req_valid, 0);
      @(negedge clk);
      redirect_valid = 0; halt = 0;
      #1;
      chk("tbl_req_valid", req_valid, 1);
      chk("tbl_req_addr", req_addr, vecs[i].exp_addr);
    end

    // Random run: bench is the memory, model tracks the next PC the decoder should see
    do_reset();
    exp_pc = RST_PC; pend = 0; stop_m = 0; prev_wait = 0; prev_addr = '0; dly = 0; pops = 0;
    pend_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (pend && dly == 1) begin
        rsp_valid = 1; rsp_data = mem_f(pend_addr); rsp_err = err_f(pend_addr); pend = 0;
      end else begin
        rsp_valid = 0; rsp_err = 0;
        if (pend) dly--;
      end
      req_ready  = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 2) != 0);
      halt       = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0) || (stop_m && $urandom_range(0, 3) == 0);
      redirect_pc = ($urandom_range(0, 9) == 0) ? (32'hffff_fff0 | ($urandom & 32'hf))
                                                : (RST_PC | ($urandom & 32'hfff));
      #1;
      if (prev_wait) begin
        chk("rnd_hold_valid", req_valid, 1);
        chk("rnd_hold_addr", req_addr, prev_addr);
      end else if (halt) begin
        chk("rnd_halt_no_req", req_valid, 0);
      end
      chk("rnd_count_range", (fifo_count <= 3'd4), 1);
      chk("rnd_valid_vs_count", inst_valid, (fifo_count != 0));
      if (req_valid && req_ready) begin
        chk("rnd_one_outstanding", pend, 0);
        chk("rnd_aligned", req_addr[1:0], 0);
        pend = 1; pend_addr = req_addr; dly = $urandom_range(1, 3);
      end
      prev_wait = req_valid && !req_ready;
      prev_addr = req_addr;
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3;
        stop_m = 0;
      end else if (inst_valid && inst_ready) begin
        chk("rnd_pop_after_err", stop_m, 0);
        chk("rnd_pc", inst_pc, exp_pc);
        chk("rnd_inst", inst, mem_f(exp_pc));
        chk("rnd_err", inst_err, err_f(exp_pc));
        stop_m = err_f(exp_pc);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    chk("rnd_progress", (pops > 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
